// File: rtl/instruction_fetch_stage.sv
// MIPS instruction fetch stage: issues single-outstanding imem reads at the pc,
// buffers {pc, word} pairs in a small FIFO and hands them to decode.
module instruction_fetch_stage #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_address,
  output logic                  pc_enable,
  input  logic                  redirect,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  id_valid,
  output logic [DATA_WIDTH-1:0] id_instruction,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [ADDR_WIDTH-1:0] id_pc_plus4,
  input  logic                  id_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ISSUE, WAIT, DISCARD} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_lat_q, pc_lat_d;
  logic [ADDR_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  grant, push, pop;

  // Only ISSUE has nothing outstanding, so the occupancy test alone bounds the FIFO.
  assign imem_req  = !reset && (state_q == ISSUE) && (count_q < DEPTH_C) && !redirect;
  assign imem_addr = pc_address;
  assign grant     = imem_req && imem_gnt;
  assign pc_enable = grant;

  assign push = (state_q == WAIT) && imem_rvalid && !redirect;
  assign pop  = id_valid && id_ready && !redirect;

  assign id_valid       = (count_q != '0);
  assign id_instruction = id_valid ? data_mem_q[rd_ptr_q] : '0;
  assign id_pc          = id_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign id_pc_plus4    = id_valid ? pc_mem_q[rd_ptr_q] + ADDR_WIDTH'(4) : '0;

  always_comb begin
    state_d  = state_q;
    pc_lat_d = grant ? pc_address : pc_lat_q;
    unique case (state_q)
      ISSUE: begin
        if (grant) state_d = WAIT;
      end
      WAIT: begin
        // A response arriving with the redirect is simply dropped; nothing left to discard.
        if (imem_rvalid)   state_d = ISSUE;
        else if (redirect) state_d = DISCARD;
      end
      DISCARD: begin
        if (imem_rvalid) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ISSUE;
      pc_lat_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_lat_q <= pc_lat_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= pc_lat_q;
        data_mem_q[wr_ptr_q] <= imem_rdata;
      end
    end
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Sits between the pc register and the IF/ID boundary of the MIPS pipeline.
- Issues instruction-memory reads at the current pc and buffers returned words with their pc in a small FIFO.
- Presents buffered words to decode with a valid/ready handshake.
- Tells the pc register when to advance and drops stale fetches on a branch/jump redirect.

Parameters:
- ADDR_WIDTH, 32, width of pc and memory address.
- DATA_WIDTH, 32, instruction word width.
- FIFO_DEPTH, 2, buffered instruction entries (power of two, ≥2).

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- pc_address  in  ADDR_WIDTH  current pc from the pc register.
- pc_enable  out  1  pc register updates only in cycles where this is 1.
- redirect  in  1  branch/jump taken this cycle; pc register loads the target on the same edge.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_WIDTH  read address; combinational copy of pc_address.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid; in-order, ≥1 cycle after grant.
- imem_rdata  in  DATA_WIDTH  read data.
- id_valid  out  1  decode-side entry valid.
- id_instruction  out  DATA_WIDTH  instruction at FIFO head.
- id_pc  out  ADDR_WIDTH  address of id_instruction.
- id_pc_plus4  out  ADDR_WIDTH  id_pc + 4, modulo 2^ADDR_WIDTH.
- id_ready  in  1  decode consumes head when id_valid && id_ready.

Behaviour:
- Reset, asynchronous:
  - FIFO empty; id_valid = 0; id_instruction, id_pc, id_pc_plus4 = 0 (empty-FIFO outputs are forced to 0).
  - imem_req = 0, pc_enable = 0; FSM = ISSUE; outstanding = 0; the pc latch is cleared.
- Outstanding limit: at most one request outstanding.
- FSM states and transitions:
  - ISSUE: imem_req = 1 when (occupancy + outstanding) < FIFO_DEPTH and redirect = 0.
    - On imem_req && imem_gnt: capture pc_address into the pc latch, pulse pc_enable = 1 in the same cycle, go to WAIT.
    - Without a grant, hold imem_req high, keep imem_addr stable, and keep pc_enable = 0.
  - WAIT: imem_req = 0. On imem_rvalid, push {pc latch, imem_rdata} into the FIFO and go to ISSUE. A new request may be issued the following cycle; there is no same-cycle back-to-back issue.
  - DISCARD: entered from WAIT on redirect. Wait for imem_rvalid, drop the data without pushing, then go to ISSUE.
- Redirect, in any state:
  - Flush the FIFO on that edge; id_valid = 0 from the next cycle.
  - Force imem_req = 0 and pc_enable = 0 in the redirect cycle.
  - If the state is WAIT, or an rvalid arrives in the same cycle, the response is discarded.
  - Redirect in ISSUE: stay in ISSUE and fetch the new pc the next cycle.
- FIFO:
  - Push and pop in the same cycle are allowed when non-empty; occupancy is unchanged.
  - A push is never attempted when full, which the issue rule guarantees.
  - A pop is ignored when empty.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a grant in cycle N with rvalid in cycle N+k gives id_valid in cycle N+k+1 (registered FIFO output).
- Throughput: with single-cycle memory (k = 1), one instruction per 2 cycles.
- id_pc_plus4 wraps at 32'hFFFFFFFC + 4 = 0.
- A redirect coinciding with id_ready pop: the flush wins.

Test Plan:
- Reset mid-WAIT, then release: id_valid = 0, imem_req = 0 during reset; after release, the first request goes out at pc_address = 0 and no stale data is pushed.
- pc = 0x00400000, gnt immediate, rvalid +1 cycle with data 0x8C080004, id_ready = 1: id_valid rises 2 cycles after grant with id_pc = 0x00400000 and id_pc_plus4 = 0x00400004; pc_enable pulses exactly once per grant.
- id_ready = 0 with FIFO_DEPTH = 2: after two entries, imem_req stays 0. Raising id_ready drains 0x00400000 then 0x00400004 in order, and fetch resumes.
- imem_gnt held low 3 cycles: imem_req and imem_addr stay stable and pc_enable stays 0 until the grant.
- Redirect while in WAIT: that cycle's rvalid data 0xDEADBEEF never appears on id_instruction. The FIFO empties, and the next id_pc equals the redirect target 0x00400100.
- pc = 0xFFFFFFFC fetched: id_pc_plus4 = 0x00000000.
